mcu: RTL and testbench
======================

MCU -- requirements
Module: mcu

Interface
REQ-001 The block SHALL expose parameter SONG_W, default 2, meaning the width of the song index (number of songs = 2^SONG_W).
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port play_button, input, 1 bit: a play/pause request, pre-debounced and single-cycle.
REQ-005 The block SHALL have port next_button, input, 1 bit: a skip-to-next-song request, pre-debounced and single-cycle.
REQ-006 The block SHALL have port song_done, input, 1 bit: the player's one-cycle end-of-song indication.
REQ-007 The block SHALL have port play, output, 1 bit: when high, the player runs.
REQ-008 The block SHALL have port reset_player, output, SONG_W-independent 1 bit: a one-cycle pulse that restarts the player at the beginning of the current song.
REQ-009 The block SHALL have port song, output, SONG_W bits: the index of the selected song.

Function
REQ-010 The controller SHALL be a registered FSM with three states: PAUSED (play=0), PLAYING (play=1) and ADVANCE (transient, play=0).
REQ-011 All outputs SHALL be registered and take their new values on the same rising edge on which the triggering input is sampled high, giving a latency of 1 cycle.
REQ-012 When play_button is high in PAUSED, the controller SHALL move to PLAYING.
REQ-013 When play_button is high in PLAYING, the controller SHALL move to PAUSED.
REQ-014 When next_button is high in any state, the controller SHALL enter ADVANCE for exactly one cycle.
REQ-015 On entering ADVANCE, song SHALL increment by 1 modulo 2^SONG_W (3 wraps to 0 for SONG_W=2), reset_player SHALL be 1 and play SHALL be 0.
REQ-016 After ADVANCE, the controller SHALL go to PAUSED, and reset_player SHALL return to 0.
REQ-017 song_done high SHALL be treated exactly like next_button, including while PAUSED.
REQ-018 Priority for simultaneous inputs SHALL be reset > next_button > song_done > play_button; a lower-priority request in the same cycle SHALL be discarded, not queued.
REQ-019 Inputs sampled while in ADVANCE SHALL be evaluated normally: next_button or song_done re-enters ADVANCE, and play_button goes to PLAYING.
REQ-020 An input held high for N cycles SHALL act as N requests; the block performs no edge detection.
REQ-021 song SHALL change only on an ADVANCE entry or on reset.

Reset
REQ-022 While reset is high at a clock edge, the block SHALL set the state to PAUSED, play=0, song=0 and reset_player=0.
REQ-023 Reset SHALL override any pending request in the same cycle.
REQ-024 Reset SHALL abort a mid-song or ADVANCE state with no extra reset_player pulse.

Configuration
REQ-025 When macro MCU_AUTOPLAY_EN is defined, a song_done-triggered ADVANCE that was entered from PLAYING SHALL return to PLAYING instead of PAUSED.
REQ-026 When MCU_AUTOPLAY_EN is defined, a next_button-triggered ADVANCE SHALL still go to PAUSED.
REQ-027 When MCU_AUTOPLAY_EN is undefined, behaviour SHALL be exactly REQ-016 and REQ-017.

Structure
REQ-028 Package mcu_pkg SHALL hold the state enumeration type (PAUSED, PLAYING, ADVANCE) and the default SONG_W constant.
REQ-029 The song index register and its wrap logic SHALL be one sub-module, mcu_song_counter (inputs clk, reset, inc; output song).
REQ-030 The FSM SHALL reside in mcu.

Verification
REQ-031 The bench SHALL check: reset for 2 cycles, then idle -> play=0, song=0, reset_player=0.
REQ-032 The bench SHALL check: a 1-cycle play_button from PAUSED -> play=1 next cycle; a second pulse -> play=0.
REQ-033 The bench SHALL check: five 1-cycle next_button pulses spaced 3 cycles apart -> song sequence 1,2,3,0,1, each with a single-cycle reset_player pulse and play=0.
REQ-034 The bench SHALL check: playing song 1, then a 1-cycle song_done -> song=2, reset_player pulse, play=0 (play=1 after ADVANCE with MCU_AUTOPLAY_EN).
REQ-035 The bench SHALL check: play_button and next_button high in the same cycle while PLAYING -> ADVANCE wins, song increments, and the following state is PAUSED.
REQ-036 The bench SHALL check: reset asserted while PLAYING song 3 -> next cycle play=0, song=0, reset_player=0.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared definitions for the music-player controller: FSM state encoding
// and the default song-index width.
package mcu_pkg;

  // Controller states; ADVANCE lasts one cycle while the next song is loaded.
  typedef enum logic [1:0] {
    PAUSED  = 2'd0,
    PLAYING = 2'd1,
    ADVANCE = 2'd2
  } state_t;

  // Default width of the song index (2^width songs).
  localparam int MCU_SONG_W_DEFAULT = 2;

endpackage

// File: rtl/mcu_song_counter.sv
// Song index register. Increments by one on inc and wraps naturally at
// 2^SONG_W; cleared by synchronous reset.
module mcu_song_counter #(
  parameter int SONG_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  output logic [SONG_W-1:0] song
);

  logic [SONG_W-1:0] r_song;

  // Song index: clear on reset, step (with wrap) on each advance request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_song <= '0;
    end else if (inc) begin
      r_song <= r_song + SONG_W'(1);
    end
  end

  assign song = r_song;

endmodule

// File: rtl/mcu.sv
// Music-player controller top. Three-state FSM (PAUSED / PLAYING / ADVANCE)
// with fully registered outputs; the song index lives in mcu_song_counter.
// Optional feature macro: MCU_AUTOPLAY_EN -- when defined, a song_done
// arriving while PLAYING resumes playback after the one-cycle ADVANCE.
module mcu
  import mcu_pkg::*;
#(
  parameter int SONG_W = MCU_SONG_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_button,
  input  logic              next_button,
  input  logic              song_done,
  output logic              play,
  output logic              reset_player,
  output logic [SONG_W-1:0] song
);

  state_t r_state;
  state_t w_state_next;
  logic   w_adv;
  logic   r_play;
  logic   r_reset_player;
`ifdef MCU_AUTOPLAY_EN
  // Set when the current ADVANCE came from song_done while PLAYING.
  logic   r_resume;
  logic   w_resume_next;
`endif

  // Any skip request (explicit or end-of-song) starts an advance.
  assign w_adv = next_button | song_done;

  // Next-state logic; priority next_button > song_done > play_button is
  // implicit in the if/else order, and losers are simply dropped.
  always_comb begin
    w_state_next = r_state;
`ifdef MCU_AUTOPLAY_EN
    w_resume_next = 1'b0;
`endif
    if (w_adv) begin
      w_state_next = ADVANCE;
`ifdef MCU_AUTOPLAY_EN
      // Only an end-of-song from PLAYING resumes; a manual skip never does.
      w_resume_next = song_done & ~next_button & (r_state == PLAYING);
`endif
    end else if (play_button) begin
      w_state_next = (r_state == PLAYING) ? PAUSED : PLAYING;
    end else if (r_state == ADVANCE) begin
`ifdef MCU_AUTOPLAY_EN
      w_state_next = r_resume ? PLAYING : PAUSED;
`else
      w_state_next = PAUSED;
`endif
    end else if (r_state != PAUSED && r_state != PLAYING) begin
      // Unused encoding recovers to a safe idle state.
      w_state_next = PAUSED;
    end
  end

  // State and output registers; outputs are decoded from the next state so
  // they change on the same edge that samples the request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= PAUSED;
      r_play         <= 1'b0;
      r_reset_player <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_play         <= (w_state_next == PLAYING);
      r_reset_player <= (w_state_next == ADVANCE);
    end
  end

`ifdef MCU_AUTOPLAY_EN
  // Remember whether the pending ADVANCE should hand back to PLAYING.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_resume <= 1'b0;
    end else begin
      r_resume <= w_resume_next;
    end
  end
`endif

  mcu_song_counter #(
    .SONG_W(SONG_W)
  ) u_song_counter (
    .clk  (clk),
    .reset(reset),
    .inc  (w_adv),
    .song (song)
  );

  assign play         = r_play;
  assign reset_player = r_reset_player;

endmodule

// File: tb/tb_mcu.sv
// Directed self-checking bench for the mcu controller (SONG_W = 2).
// Each observation compares the packed vector {play, reset_player, song}.
`timescale 1ns/1ps
module tb_mcu;

  logic       clk;
  logic       reset;
  logic       play_button;
  logic       next_button;
  logic       song_done;
  logic       play;
  logic       reset_player;
  logic [1:0] song;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_v;
  logic [3:0] got_v;

`ifdef MCU_AUTOPLAY_EN
  localparam logic AP = 1'b1;
`else
  localparam logic AP = 1'b0;
`endif

  mcu #(.SONG_W(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .play_button (play_button),
    .next_button (next_button),
    .song_done   (song_done),
    .play        (play),
    .reset_player(reset_player),
    .song        (song)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, let the edge sample them, observe 1 ns later.
  task automatic step(input logic p, input logic n, input logic d, input logic r);
    play_button = p;
    next_button = n;
    song_done   = d;
    reset       = r;
    @(posedge clk);
    #1;
    play_button = 1'b0;
    next_button = 1'b0;
    song_done   = 1'b0;
    reset       = 1'b0;
    got_v = {play, reset_player, song};
    $display("t=%0t in(p=%0b n=%0b d=%0b r=%0b) -> play=%0b reset_player=%0b song=%0d",
             $time, p, n, d, r, play, reset_player, song);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      exp_v = 4'b0000;
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got {play,rp,song}=%b required %b", i, got_v, exp_v);
      end
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    exp_v = 4'b0000;
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL reset_idle: got {play,rp,song}=%b required %b", got_v, exp_v);
    end
  endtask

  task automatic test_play_toggle();
    logic [3:0] exp_tab [4] = '{4'b1000, 4'b1000, 4'b0000, 4'b0000};
    logic       btn_tab [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      step(btn_tab[i], 1'b0, 1'b0, 1'b0);
      checks++;
      if (got_v !== exp_tab[i]) begin
        errors++;
        $display("FAIL play_toggle[%0d]: got {play,rp,song}=%b required %b", i, got_v, exp_tab[i]);
      end
    end
  endtask

  task automatic test_next_wrap();
    logic [1:0] song_tab [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      exp_v = {1'b0, 1'b1, song_tab[i]};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL next_pulse[%0d]: got {play,rp,song}=%b required %b", i, got_v, exp_v);
      end
      for (int k = 0; k < 2; k++) begin
        step(1'b0, 1'b0, 1'b0, 1'b0);
        exp_v = {1'b0, 1'b0, song_tab[i]};
        checks++;
        if (got_v !== exp_v) begin
          errors++;
          $display("FAIL next_after[%0d.%0d]: got {play,rp,song}=%b required %b", i, k, got_v, exp_v);
        end
      end
    end
  endtask

  task automatic test_song_done();
    // Song 1, paused: start playing.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    exp_v = {1'b1, 1'b0, 2'd1};
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL done_start: got {play,rp,song}=%b required %b", got_v, exp_v);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    exp_v = {1'b0, 1'b1, 2'd2};
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL done_advance: got {play,rp,song}=%b required %b", got_v, exp_v);
    end
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      exp_v = {AP, 1'b0, 2'd2};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL done_after[%0d]: got {play,rp,song}=%b required %b", k, got_v, exp_v);
      end
    end
  endtask

  task automatic test_simultaneous();
    // Get into PLAYING (autoplay builds are already there).
    if (AP == 1'b0) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      exp_v = {1'b1, 1'b0, 2'd2};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL simul_setup: got {play,rp,song}=%b required %b", got_v, exp_v);
      end
    end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    exp_v = {1'b0, 1'b1, 2'd3};
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL simul_advance: got {play,rp,song}=%b required %b", got_v, exp_v);
    end
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      exp_v = {1'b0, 1'b0, 2'd3};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL simul_paused[%0d]: got {play,rp,song}=%b required %b", k, got_v, exp_v);
      end
    end
  endtask

  task automatic test_reset_playing();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    exp_v = {1'b1, 1'b0, 2'd3};
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL rstplay_setup: got {play,rp,song}=%b required %b", got_v, exp_v);
    end
    // Reset with competing requests: reset must win and emit no pulse.
    step(1'b1, 1'b1, 1'b1, 1'b1);
    exp_v = 4'b0000;
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL rstplay_reset: got {play,rp,song}=%b required %b", got_v, exp_v);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL rstplay_idle: got {play,rp,song}=%b required %b", got_v, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    // Stimulus {play, next, done} and expected {play, rp, song} per cycle.
    logic [2:0] in_tab  [9] = '{3'b010, 3'b100, 3'b010, 3'b010, 3'b000,
                                3'b001, 3'b000, 3'b101, 3'b000};
    logic [3:0] exp_tab [9] = '{4'b0101, 4'b1001, 4'b0110, 4'b0111, 4'b0011,
                                4'b0100, 4'b0000, 4'b0101, 4'b0001};
    for (int i = 0; i < 9; i++) begin
      step(in_tab[i][2], in_tab[i][1], in_tab[i][0], 1'b0);
      checks++;
      if (got_v !== exp_tab[i]) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got {play,rp,song}=%b required %b", i, got_v, exp_tab[i]);
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    play_button = 1'b0;
    next_button = 1'b0;
    song_done   = 1'b0;
    @(negedge clk);
    test_reset();
    test_play_toggle();
    test_next_wrap();
    test_song_done();
    test_simultaneous();
    test_reset_playing();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "time limit");
  end

endmodule
